// File: rtl/multi_channel_timer_if.sv
// Bus bundle for multi_channel_timer: configuration, run control, status and count readback.
// The controller drives the master side; the timer block sits on the slave side.
interface multi_channel_timer_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 17,
  parameter int CH_W   = 2
) ();
  logic              cfg_valid;
  logic [CH_W-1:0]   cfg_ch;
  logic [WIDTH-1:0]  cfg_target;
  logic [1:0]        cfg_mode;
  logic              cfg_err;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] wave;
  logic [CH_W-1:0]   rd_ch;
  logic [WIDTH-1:0]  rd_count;

  modport master (
    output cfg_valid, cfg_ch, cfg_target, cfg_mode, start, stop, rd_ch,
    input  cfg_err, busy, expire, wave, rd_count
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_target, cfg_mode, start, stop, rd_ch,
    output cfg_err, busy, expire, wave, rd_count
  );
endinterface

// File: rtl/multi_channel_timer.sv
// N-channel programmable interval timer: one-shot / periodic / toggle per channel,
// one-cycle expiry pulses, square-wave outputs and registered count readback.

module multi_channel_timer_ch #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] cfg_target,
  input  logic [1:0]       cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             expire,
  output logic             wave,
  output logic             cfg_rej,
  output logic [WIDTH-1:0] count
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_TOGGLE  = 2'b10;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] target, target_nxt, count_nxt;
  logic [1:0]       mode, mode_nxt;
  logic             expire_nxt, wave_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      target <= '0;
      mode   <= MODE_ONESHOT;
      expire <= 1'b0;
      wave   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      target <= target_nxt;
      mode   <= mode_nxt;
      expire <= expire_nxt;
      wave   <= wave_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    target_nxt = target;
    mode_nxt   = mode;
    expire_nxt = 1'b0;
    wave_nxt   = wave;
    case (state)
      IDLE: begin
        // Config lands before the start so a same-cycle start runs with the new settings.
        if (cfg_wr) begin
          target_nxt = cfg_target;
          mode_nxt   = cfg_mode;
          wave_nxt   = 1'b0;
        end
        if (start && !stop) begin
          state_nxt = RUN;
          count_nxt = '0;
        end
      end
      RUN: begin
        if (start && !stop) begin
          count_nxt = '0;
        end else if (count == target) begin
          // Terminal count still pulses when a stop coincides, then drops to IDLE.
          count_nxt  = '0;
          expire_nxt = 1'b1;
          if (mode == MODE_TOGGLE) wave_nxt = ~wave;
          if (mode == MODE_ONESHOT || stop) state_nxt = IDLE;
        end else if (stop) begin
          state_nxt = IDLE;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == RUN);
    cfg_rej = cfg_wr && (state == RUN);
  end
endmodule

module multi_channel_timer #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 17,
  parameter int CH_W   = 2
) (
  input logic                clk,
  input logic                reset,
  multi_channel_timer_if.slave bus
);
  logic [NUM_CH-1:0][WIDTH-1:0] count;
  logic [NUM_CH-1:0]            busy, expire, wave, cfg_rej;
  logic                         cfg_bad, rd_ok;
  logic                         cfg_err_q;
  logic [WIDTH-1:0]             rd_count_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_channel_timer_ch #(.WIDTH(WIDTH)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .cfg_wr     (bus.cfg_valid && (bus.cfg_ch == CH_W'(i))),
      .cfg_target (bus.cfg_target),
      .cfg_mode   (bus.cfg_mode),
      .start      (bus.start[i]),
      .stop       (bus.stop[i]),
      .busy       (busy[i]),
      .expire     (expire[i]),
      .wave       (wave[i]),
      .cfg_rej    (cfg_rej[i]),
      .count      (count[i])
    );
  end

  assign cfg_bad = bus.cfg_valid && (int'(bus.cfg_ch) >= NUM_CH);
  assign rd_ok   = int'(bus.rd_ch) < NUM_CH;

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_err_q  <= 1'b0;
      rd_count_q <= '0;
    end else begin
      cfg_err_q  <= cfg_bad | (|cfg_rej);
      rd_count_q <= rd_ok ? count[bus.rd_ch] : '0;
    end
  end

  assign bus.busy     = busy;
  assign bus.expire   = expire;
  assign bus.wave     = wave;
  assign bus.cfg_err  = cfg_err_q;
  assign bus.rd_count = rd_count_q;
endmodule
